// File: rtl/cq_receiver.sv
// NVMe completion-queue receiver: AXI4 write slave for CQ entries, in-order host
// responses by command ID, and CQ1 head doorbell writer on an AXI4 master port.
module cq_receiver #(
  parameter int OUTSTANDING   = 16,
  parameter int NS_ID_WIDTH   = 4,
  parameter int NS_ADDR_WIDTH = 32,
  parameter int NS_DATA_WIDTH = 128,
  parameter int NM_ADDR_WIDTH = 32,
  parameter int NM_DATA_WIDTH = 128,
  parameter logic [NS_ADDR_WIDTH-1:0] CQ_BASE     = 'h20400,
  parameter logic [NM_ADDR_WIDTH-1:0] CQHDBL_ADDR = 'h100C
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NS_ID_WIDTH-1:0]       ns_awid,
  input  logic [NS_ADDR_WIDTH-1:0]     ns_awaddr,
  input  logic [7:0]                   ns_awlen,
  input  logic [2:0]                   ns_awsize,
  input  logic [1:0]                   ns_awburst,
  input  logic                         ns_awvalid,
  output logic                         ns_awready,
  input  logic [NS_DATA_WIDTH-1:0]     ns_wdata,
  input  logic [NS_DATA_WIDTH/8-1:0]   ns_wstrb,
  input  logic                         ns_wlast,
  input  logic                         ns_wvalid,
  output logic                         ns_wready,
  output logic [NS_ID_WIDTH-1:0]       ns_bid,
  output logic [1:0]                   ns_bresp,
  output logic                         ns_bvalid,
  input  logic                         ns_bready,
  output logic [1:0]                   hp_bresp,
  output logic                         hp_bvalid,
  input  logic                         hp_bready,
  output logic [$clog2(OUTSTANDING)-1:0] cqdb_sqhead,
  output logic [NM_ADDR_WIDTH-1:0]     nm_awaddr,
  output logic [7:0]                   nm_awlen,
  output logic [2:0]                   nm_awsize,
  output logic [1:0]                   nm_awburst,
  output logic                         nm_awvalid,
  input  logic                         nm_awready,
  output logic [NM_DATA_WIDTH-1:0]     nm_wdata,
  output logic [NM_DATA_WIDTH/8-1:0]   nm_wstrb,
  output logic                         nm_wlast,
  output logic                         nm_wvalid,
  input  logic                         nm_wready,
  input  logic [1:0]                   nm_bresp,
  input  logic                         nm_bvalid,
  output logic                         nm_bready,
  output logic                         err_phase,
  output logic                         err_dup
);

  localparam int PW   = $clog2(OUTSTANDING);
  localparam int LANE = int'(CQHDBL_ADDR[$clog2(NM_DATA_WIDTH/8)-1:2]);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} ing_state_t;
  typedef enum logic [1:0] {DB_IDLE, DB_SEND, DB_RESP} db_state_t;

  ing_state_t ing_state;
  db_state_t  db_state;

  logic [PW-1:0]          cq_head, rung_head, db_val, rsp_ptr;
  logic                   exp_phase;
  logic [OUTSTANDING-1:0] valid, err;
  logic [31:0]            dw3;
  logic [PW-1:0]          slot;
  logic                   beat_hs, beat_ok, hp_hs;

  assign dw3     = ns_wdata[127:96];
  assign slot    = dw3[PW-1:0];
  assign beat_hs = ns_wvalid && ns_wready;
  assign beat_ok = beat_hs && (dw3[16] == exp_phase);
  assign hp_hs   = hp_bvalid && hp_bready;

  assign ns_bresp    = 2'b00;
  assign hp_bvalid   = valid[rsp_ptr];
  assign hp_bresp    = (valid[rsp_ptr] && err[rsp_ptr]) ? 2'b10 : 2'b00;
  assign cqdb_sqhead = rsp_ptr;

  // Ingress: one burst at a time, single B response per burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ing_state  <= S_IDLE;
      ns_awready <= 1'b1;
      ns_wready  <= 1'b0;
      ns_bvalid  <= 1'b0;
      ns_bid     <= '0;
    end else begin
      case (ing_state)
        S_IDLE: if (ns_awvalid) begin
          ns_bid     <= ns_awid;
          ns_awready <= 1'b0;
          ns_wready  <= 1'b1;
          ing_state  <= S_DATA;
        end
        S_DATA: if (ns_wvalid && ns_wlast) begin
          ns_wready <= 1'b0;
          ns_bvalid <= 1'b1;
          ing_state <= S_RESP;
        end
        S_RESP: if (ns_bready) begin
          ns_bvalid  <= 1'b0;
          ns_awready <= 1'b1;
          ing_state  <= S_IDLE;
        end
        default: ing_state <= S_IDLE;
      endcase
    end
  end

  // Reorder table: set on accepted entry, cleared as the host takes the response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid     <= '0;
      cq_head   <= '0;
      exp_phase <= 1'b1;
      rsp_ptr   <= '0;
      err_phase <= 1'b0;
      err_dup   <= 1'b0;
    end else begin
      if (hp_hs) begin
        valid[rsp_ptr] <= 1'b0;
        rsp_ptr        <= rsp_ptr + PW'(1);
      end
      if (beat_hs && !beat_ok) err_phase <= 1'b1;
      if (beat_ok) begin
        cq_head <= cq_head + PW'(1);
        if (cq_head == PW'(OUTSTANDING - 1)) exp_phase <= ~exp_phase;
        if (valid[slot]) err_dup <= 1'b1;
        else             valid[slot] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok && !valid[slot]) err[slot] <= |dw3[31:17];
  end

  // Doorbell: snapshot cq_head, send AW and W independently, wait for B
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_state   <= DB_IDLE;
      nm_awvalid <= 1'b0;
      nm_wvalid  <= 1'b0;
      nm_bready  <= 1'b0;
      rung_head  <= '0;
    end else begin
      case (db_state)
        DB_IDLE: if (cq_head != rung_head) begin
          nm_awvalid <= 1'b1;
          nm_wvalid  <= 1'b1;
          db_state   <= DB_SEND;
        end
        DB_SEND: begin
          if (nm_awready) nm_awvalid <= 1'b0;
          if (nm_wready)  nm_wvalid  <= 1'b0;
          if ((!nm_awvalid || nm_awready) && (!nm_wvalid || nm_wready)) begin
            nm_bready <= 1'b1;
            db_state  <= DB_RESP;
          end
        end
        DB_RESP: if (nm_bvalid) begin
          nm_bready <= 1'b0;
          rung_head <= db_val;
          db_state  <= DB_IDLE;
        end
        default: db_state <= DB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (db_state == DB_IDLE && cq_head != rung_head) db_val <= cq_head;
  end

  assign nm_awaddr  = CQHDBL_ADDR;
  assign nm_awlen   = 8'd0;
  assign nm_awsize  = 3'd2;
  assign nm_awburst = 2'b01;
  assign nm_wlast   = 1'b1;

  always_comb begin
    nm_wdata = '0;
    nm_wstrb = '0;
    nm_wdata[32*LANE +: 32] = 32'(db_val);
    nm_wstrb[4*LANE +: 4]   = 4'hF;
  end

  logic unused_ok;
  assign unused_ok = ^{ns_awaddr, ns_awlen, ns_awsize, ns_awburst, ns_wdata[95:0],
                       ns_wstrb, dw3[15:PW], nm_bresp, CQ_BASE};

endmodule

// File: doc/cq_receiver.md
# cq_receiver

Completion-side counterpart of the NVMe write-command driver. Acts as the AXI4 write slave that the NVMe controller targets when it posts 16-byte completion queue entries into the CQ region. It validates phase, reorders completions by command ID, returns in-order write responses to the host, and frees submission/write-buffer slots back to the driver. It also rings the CQ1 head doorbell on the controller through an AXI4 master port.

## Interface
Parameters:
- OUTSTANDING, 16, CQ/SQ depth and number of slots (power of two)
- NS_ID_WIDTH, 4, controller-side AXI ID width
- NS_ADDR_WIDTH, 32, controller-side address width
- NS_DATA_WIDTH, 128, controller-side data width (one CQ entry per beat)
- NM_ADDR_WIDTH, 32, doorbell master address width
- NM_DATA_WIDTH, 128, doorbell master data width
- CQ_BASE, 'h20400, CQ region byte base
- CQHDBL_ADDR, 'h100C, CQ1 head doorbell address

Ports (reset rstn, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- ns_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID/ADDR/8/3/2/1  controller write address
- ns_awready  out  1
- ns_wdata/wstrb/wlast/wvalid  in  128/16/1/1  CQ entry beats
- ns_wready  out  1
- ns_bid/bresp/bvalid  out  ID/2/1;  ns_bready  in  1
- hp_bresp  out  2  host write response (00 OKAY, 10 SLVERR)
- hp_bvalid  out  1;  hp_bready  in  1
- cqdb_sqhead  out  log2(OUTSTANDING)  oldest unresponded slot (driver full check)
- nm_awaddr/awlen/awsize/awburst/awvalid  out  32/8/3/2/1;  nm_awready  in  1
- nm_wdata/wstrb/wlast/wvalid  out  128/16/1/1;  nm_wready  in  1
- nm_bresp  in  2;  nm_bvalid  in  1;  nm_bready  out  1
- err_phase, err_dup  out  1  sticky error flags

## Operation
- Ingress FSM: IDLE (awready=1) -> DATA on aw handshake (latch awid) -> RESP after wlast beat -> IDLE on ns_bready. ns_wready=1 throughout DATA; ns_bresp always 00; ns_bid = latched awid.
- Per beat: DW3[16] phase, DW3[15:0] CID, DW3[31:17] status, DW2[15:0] SQHD (ignored). Slot = CID[3:0].
- Phase check: expected phase resets to 1 and toggles when cq_head wraps OUTSTANDING-1 -> 0. Mismatch: drop entry, set err_phase; cq_head does not advance.
- Accepted entry: cq_head += 1 (mod OUTSTANDING). If valid[slot] is already 1: set err_dup, keep the existing entry. Otherwise set valid[slot], and store err[slot] = (status != 0).
- Response pointer rsp_ptr (reset 0): hp_bvalid = valid[rsp_ptr]; hp_bresp = err[rsp_ptr] ? 10 : 00. On hp_bready&hp_bvalid: clear valid[rsp_ptr], rsp_ptr += 1 (wraps). cqdb_sqhead = rsp_ptr. Responses are strictly in CID order regardless of arrival order.
- Doorbell FSM: DB_IDLE -> DB_SEND when cq_head != rung_head (snapshot db_val = cq_head). In DB_SEND, nm_awvalid and nm_wvalid are handshaken independently (a per-channel done flag drops each valid after its handshake). Go to DB_RESP once both are done. DB_RESP: nm_bready=1; on nm_bvalid, rung_head <= db_val -> DB_IDLE. Entries arriving in flight are coalesced into the next doorbell.
- Doorbell fields: nm_awaddr=CQHDBL_ADDR, awlen 0, awsize 2, awburst 01. nm_wdata carries 32'(db_val) in lane CQHDBL_ADDR[3:2], zeros elsewhere; nm_wstrb = 4'hF in that lane; wlast 1. nm_bresp is ignored.

## Timing
- Reset values: ns_awready 1, ns_wready 0, ns_bvalid 0, ns_bid 0, ns_bresp 0, hp_bvalid 0, hp_bresp 0, cqdb_sqhead 0, nm_awvalid 0, nm_wvalid 0, nm_bready 0, err flags 0. Reset mid-burst or mid-doorbell drops all state.
- Beat handshake at cycle t -> valid[slot] visible at t+1 -> hp_bvalid at t+1 if slot==rsp_ptr.
- Same-cycle table set (new entry) and clear (hp_b) on different slots are both honoured.
- cq_head != rung_head at cycle t -> nm_awvalid/nm_wvalid at t+1.
- Wrap: slot 15 -> 0 for rsp_ptr and cq_head; phase toggles on cq_head wrap only.

## Test plan
- Single entry CID 0, phase 1, status 0 -> ns_b OKAY; hp_bvalid with bresp 00 one cycle after the beat; cqdb_sqhead 0->1. Doorbell writes 1 to 'h100C with wstrb 'hF000.
- Out of order CIDs 2,1,0 in one 3-beat burst -> hp_b three responses in order 0,1,2; single coalesced doorbell value 3 if DB busy.
- Status nonzero on CID 4 -> hp_bresp 10 for that response only.
- 16 entries then entry with phase 1 -> dropped, err_phase=1, cq_head stays 0. Entry with phase 0 -> accepted.
- hp_bready held low: fill 16 slots, then duplicate CID 3 -> err_dup=1; table unchanged.
- Doorbell stalls (nm_wready low 5 cycles, nm_awready immediate) -> awvalid drops after 1 cycle, wvalid held; bready only after both.
